pc_sequencer: RTL



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings and constants for the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        PS_BOOT = 2'd0,
        PS_RUN  = 2'd1,
        PS_HALT = 2'd2
    } pc_state_t;

    localparam int          INSTR_W            = 32;
    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam int          DEFAULT_IMEM_BYTES = 1024;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, fetch-latency tracking, redirect/stall/halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_npc,
    output logic        instr_valid,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

    pc_state_t   state;
    pc_state_t   state_nx;
    logic [31:0] pc_nx;
    logic [31:0] fetch_pc_nx;
    logic        valid_nx;
    logic        err_nx;
    logic        target_bad;

    assign target_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= IMEM_LIMIT);
    assign fetch_npc  = fetch_pc + PC_STEP;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        fetch_pc_nx = pc;
        valid_nx    = 1'b0;
        err_nx      = addr_err;
        case (state)
            PS_BOOT: begin
                state_nx = PS_RUN;
                pc_nx    = pc + PC_STEP;
            end
            PS_RUN: begin
                if (halt) begin
                    state_nx = PS_HALT;
                end else if (redirect) begin
                    // Misaligned targets are still taken, just forced onto a word boundary.
                    pc_nx = {redirect_pc[31:2], 2'b00};
                    if (target_bad) begin
                        err_nx = 1'b1;
                    end
                end else if (stall) begin
                    fetch_pc_nx = fetch_pc;
                    valid_nx    = instr_valid;
                end else begin
                    pc_nx    = pc + PC_STEP;
                    valid_nx = 1'b1;
                end
            end
            PS_HALT: begin
                // PC stays put so the RAM re-primes on the held address after resume.
                if (resume) begin
                    state_nx = PS_RUN;
                end
            end
            default: begin
                state_nx = PS_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PS_BOOT;
            pc          <= RESET_PC;
            fetch_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            fetch_pc    <= fetch_pc_nx;
            instr_valid <= valid_nx;
            addr_err    <= err_nx;
            fetch_count <= fetch_count + {31'd0, instr_valid & ~stall};
        end
    end

endmodule

`default_nettype wire
